// File: rtl/dm_lut_pkg.sv
// -----------------------------------------------------------------------------
// dm_lut_pkg
// Shared constants and helpers for the programmable data-memory pointer table.
//   DM_SEL_W, DM_AW, DM_STRIDE : default selector width, pointer width and
//                                post-increment amount
//   dm_ptr_t                   : pointer type at the default width
//   dm_lut_default()           : reset value of table entry k
// -----------------------------------------------------------------------------
package dm_lut_pkg;

  localparam int DM_SEL_W  = 2;
  localparam int DM_AW     = 8;
  localparam int DM_STRIDE = 1;

  // Widest legal pointer; callers truncate to their own AW.
  localparam int DM_AW_MAX = 16;

  typedef logic [DM_AW-1:0] dm_ptr_t;

  // Entries 0..depth-2 reset to k+3 (the legacy fixed table started at 3);
  // the last entry resets to all-ones so it points at the top of memory.
  function automatic logic [DM_AW_MAX-1:0] dm_lut_default(input int k,
                                                          input int depth,
                                                          input int aw);
    logic [DM_AW_MAX-1:0] val;
    if (k < depth - 1) begin
      val = DM_AW_MAX'(k + 3);
    end else begin
      val = DM_AW_MAX'((1 << aw) - 1);
    end
    return val;
  endfunction

endpackage

// File: rtl/dm_ptr_lut.sv
// -----------------------------------------------------------------------------
// dm_ptr_lut
// Programmable data-memory address pointer table. Holds 2**SEL_W pointers of
// AW bits; a read returns the selected pointer one cycle later, optionally
// post-incrementing it by STRIDE (modulo 2**AW) for streaming access.
//
// Ports
//   CLK        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   ptr_i      in   read selector
//   rd_en      in   read request for entry ptr_i
//   inc_en     in   post-increment entry ptr_i (only with rd_en)
//   wr_en      in   program entry wr_sel with wr_data
//   wr_sel     in   write selector
//   wr_data    in   value to program
//   dm_o       out  registered pointer value
//   dm_vld_o   out  dm_o valid, one cycle after an accepted read
//   wrap_err_o out  sticky post-increment wrap flag
//                   (only when DM_PTR_LUT_WRAP_CHK_EN is defined)
//
// Same-edge priority: reads see the pre-edge value; a write to the entry
// being incremented wins and the increment is dropped.
// -----------------------------------------------------------------------------
module dm_ptr_lut
  import dm_lut_pkg::*;
#(
  parameter int SEL_W  = DM_SEL_W,
  parameter int AW     = DM_AW,
  parameter int STRIDE = DM_STRIDE
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             rd_en,
  input  logic             inc_en,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [AW-1:0]    wr_data,
  output logic [AW-1:0]    dm_o,
  output logic             dm_vld_o
`ifdef DM_PTR_LUT_WRAP_CHK_EN
  ,
  output logic             wrap_err_o
`endif
);

  localparam int DEPTH = 1 << SEL_W;
  localparam logic [AW-1:0] STRIDE_V = AW'(STRIDE);

  logic [DEPTH-1:0][AW-1:0] table_q;
  logic [AW-1:0]            rd_val;
  logic [AW:0]              inc_sum;
  logic                     wr_hits_inc;
  logic                     do_inc;

  assign rd_val  = table_q[ptr_i];
  // Extra bit captures the carry out of AW for the wrap checker.
  assign inc_sum = {1'b0, rd_val} + {1'b0, STRIDE_V};

  assign wr_hits_inc = wr_en && (wr_sel == ptr_i);
  assign do_inc      = rd_en && inc_en && !wr_hits_inc;

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        table_q[k] <= AW'(dm_lut_default(k, DEPTH, AW));
      end
      dm_o     <= '0;
      dm_vld_o <= 1'b0;
    end else begin
      dm_vld_o <= rd_en;
      if (rd_en) begin
        dm_o <= rd_val;
      end
      if (do_inc) begin
        table_q[ptr_i] <= inc_sum[AW-1:0];
      end
      if (wr_en) begin
        table_q[wr_sel] <= wr_data;
      end
    end
  end

`ifdef DM_PTR_LUT_WRAP_CHK_EN
  logic [DEPTH-1:0] wrap_mask;
  logic [DEPTH-1:0] wrap_mask_nxt;

  // A dropped increment (write to the same entry) never flags a wrap; a write
  // clears the flag of the entry it reprograms.
  always_comb begin
    wrap_mask_nxt = wrap_mask;
    if (do_inc && inc_sum[AW]) begin
      wrap_mask_nxt[ptr_i] = 1'b1;
    end
    if (wr_en) begin
      wrap_mask_nxt[wr_sel] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wrap_mask  <= '0;
      wrap_err_o <= 1'b0;
    end else begin
      wrap_mask  <= wrap_mask_nxt;
      wrap_err_o <= |wrap_mask_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_dm_ptr_lut.sv
module tb_dm_ptr_lut;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- default-parameter instance (SEL_W=2, AW=8, STRIDE=1)
  logic       reset, rd_en, inc_en, wr_en;
  logic [1:0] ptr_i, wr_sel;
  logic [7:0] wr_data, dm_o;
  logic       dm_vld_o;
`ifdef DM_PTR_LUT_WRAP_CHK_EN
  logic       wrap_err_o;
`endif

  dm_ptr_lut dut (
    .CLK(CLK), .reset(reset), .ptr_i(ptr_i), .rd_en(rd_en), .inc_en(inc_en),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .dm_o(dm_o), .dm_vld_o(dm_vld_o)
`ifdef DM_PTR_LUT_WRAP_CHK_EN
    , .wrap_err_o(wrap_err_o)
`endif
  );

  // ---------------- parametrised instance (SEL_W=3, AW=12, STRIDE=4)
  logic        reset2, rd_en2, inc_en2, wr_en2;
  logic [2:0]  ptr2, wr_sel2;
  logic [11:0] wr_data2, dm2;
  logic        vld2;
`ifdef DM_PTR_LUT_WRAP_CHK_EN
  logic        wrap_err2;
`endif

  dm_ptr_lut #(.SEL_W(3), .AW(12), .STRIDE(4)) dut2 (
    .CLK(CLK), .reset(reset2), .ptr_i(ptr2), .rd_en(rd_en2), .inc_en(inc_en2),
    .wr_en(wr_en2), .wr_sel(wr_sel2), .wr_data(wr_data2),
    .dm_o(dm2), .dm_vld_o(vld2)
`ifdef DM_PTR_LUT_WRAP_CHK_EN
    , .wrap_err_o(wrap_err2)
`endif
  );

  // ---------------- reference model: a table of integers, spec-level rules
  int unsigned mdl[4];
  int unsigned exp_dm;
  bit          exp_vld;
  int unsigned mdl2[8];
  int unsigned exp_dm2;
  bit          exp_vld2;
`ifdef DM_PTR_LUT_WRAP_CHK_EN
  bit          mdl_wrap[4];
  bit          exp_wrap;
`endif

  function automatic int unsigned def_val(int k, int depth, int aw);
    return (k < depth - 1) ? k + 3 : (1 << aw) - 1;
  endfunction

  // One clock of stimulus on the default instance, checked against the model.
  task automatic step(input bit rst, input bit rd, input bit inc, input int ptr,
                      input bit wr, input int wsel, input int wdata, input string tag);
    reset = rst; rd_en = rd; inc_en = inc; ptr_i = 2'(ptr);
    wr_en = wr; wr_sel = 2'(wsel); wr_data = 8'(wdata);
    if (rst) begin
      for (int k = 0; k < 4; k++) mdl[k] = def_val(k, 4, 8);
      exp_dm = 0; exp_vld = 0;
`ifdef DM_PTR_LUT_WRAP_CHK_EN
      for (int k = 0; k < 4; k++) mdl_wrap[k] = 0;
`endif
    end else begin
      exp_vld = rd;
      if (rd) exp_dm = mdl[ptr];
      if (rd && inc && !(wr && wsel == ptr)) begin
`ifdef DM_PTR_LUT_WRAP_CHK_EN
        if (mdl[ptr] + 1 > 255) mdl_wrap[ptr] = 1;
`endif
        mdl[ptr] = (mdl[ptr] + 1) % 256;
      end
      if (wr) begin
        mdl[wsel] = wdata % 256;
`ifdef DM_PTR_LUT_WRAP_CHK_EN
        mdl_wrap[wsel] = 0;
`endif
      end
    end
    @(posedge CLK); #1;
    n_cmp++;
    assert (dm_vld_o === exp_vld) else begin
      n_err++;
      $error("FAIL %s vld: got %b want %b", tag, dm_vld_o, exp_vld);
    end
    n_cmp++;
    assert (dm_o === 8'(exp_dm)) else begin
      n_err++;
      $error("FAIL %s dm_o: got %0d want %0d", tag, dm_o, exp_dm);
    end
`ifdef DM_PTR_LUT_WRAP_CHK_EN
    exp_wrap = mdl_wrap[0] | mdl_wrap[1] | mdl_wrap[2] | mdl_wrap[3];
    n_cmp++;
    assert (wrap_err_o === exp_wrap) else begin
      n_err++;
      $error("FAIL %s wrap_err: got %b want %b", tag, wrap_err_o, exp_wrap);
    end
`endif
  endtask

  task automatic step2(input bit rst, input bit rd, input bit inc, input int ptr,
                       input string tag);
    reset2 = rst; rd_en2 = rd; inc_en2 = inc; ptr2 = 3'(ptr);
    wr_en2 = 0; wr_sel2 = '0; wr_data2 = '0;
    if (rst) begin
      for (int k = 0; k < 8; k++) mdl2[k] = def_val(k, 8, 12);
      exp_dm2 = 0; exp_vld2 = 0;
    end else begin
      exp_vld2 = rd;
      if (rd) exp_dm2 = mdl2[ptr];
      if (rd && inc) mdl2[ptr] = (mdl2[ptr] + 4) % 4096;
    end
    @(posedge CLK); #1;
    n_cmp++;
    assert (vld2 === exp_vld2) else begin
      n_err++;
      $error("FAIL %s vld2: got %b want %b", tag, vld2, exp_vld2);
    end
    n_cmp++;
    assert (dm2 === 12'(exp_dm2)) else begin
      n_err++;
      $error("FAIL %s dm2: got %0d want %0d", tag, dm2, exp_dm2);
    end
  endtask

  initial begin
    reset = 1; rd_en = 0; inc_en = 0; ptr_i = '0; wr_en = 0; wr_sel = '0; wr_data = '0;
    reset2 = 1; rd_en2 = 0; inc_en2 = 0; ptr2 = '0; wr_en2 = 0; wr_sel2 = '0; wr_data2 = '0;
    @(posedge CLK); #1;

    // reset overrides a concurrent read
    step(1, 1, 1, 0, 1, 0, 99, "reset");

    // defaults 3,4,5,255 back to back, then an idle cycle holds dm_o
    for (int p = 0; p < 4; p++) step(0, 1, 0, p, 0, 0, 0, "defaults");
    step(0, 0, 0, 0, 0, 0, 0, "idle_hold");

    // streaming increment on ptr 1: 4,5,6,7 then 8
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, 0, 0, "stream");
    step(0, 1, 0, 1, 0, 0, 0, "stream_after");

    // wrap: 254, 255, 0
    step(0, 0, 0, 0, 1, 3, 254, "wrap_wr");
    step(0, 1, 1, 3, 0, 0, 0, "wrap_inc0");
    step(0, 1, 1, 3, 0, 0, 0, "wrap_inc1");
    step(0, 1, 0, 3, 0, 0, 0, "wrap_rd");
    step(0, 0, 0, 0, 0, 0, 0, "wrap_sticky");

    // collision: write wins over increment, read sees old value
    step(0, 1, 1, 2, 1, 2, 64, "coll");
    step(0, 1, 0, 2, 0, 0, 0, "coll_after");

    // write X while incrementing Y
    step(0, 1, 1, 1, 1, 0, 77, "wr_x_inc_y");
    step(0, 1, 0, 0, 0, 0, 0, "wr_x_rd");
    step(0, 1, 0, 1, 0, 0, 0, "inc_y_rd");

    // inc_en without rd_en is ignored
    step(0, 0, 1, 2, 0, 0, 0, "inc_no_rd");
    step(0, 1, 0, 2, 0, 0, 0, "inc_no_rd_chk");

    // reset mid-stream
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0, "mid_inc");
    step(1, 1, 1, 0, 0, 0, 0, "mid_reset");
    step(0, 1, 0, 0, 0, 0, 0, "mid_after");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 40) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 255),
           "rand");
    end

    // parametrised build: defaults 3..9, 4095; then 3,7,11
    step2(1, 0, 0, 0, "p_reset");
    for (int p = 0; p < 8; p++) step2(0, 1, 0, p, "p_defaults");
    for (int i = 0; i < 3; i++) step2(0, 1, 1, 0, "p_inc");
    step2(0, 1, 0, 0, "p_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
